pipeline_mdu_stage: RTL and testbench

// - Execute-side pipeline stage for MIPS HI/LO ops (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
// - Consumes the stall/bubble pair from the pipeline control unit and drives back available/output.
// - Owns the stage input register, a WIDTH-cycle iterative mul/div engine and the HI/LO registers.
// - Multi-cycle ops hold the upstream pipe via available=0 and feed bubbles downstream via output=0.

---
 rtl/pipeline_mdu_stage_pkg.sv | 32 +++
 rtl/pipeline_mdu_stage_iter_core.sv | 121 ++++++++++++
 rtl/pipeline_mdu_stage.sv | 133 +++++++++++++
 tb/tb_pipeline_mdu_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mdu_stage_pkg.sv
// Shared types and helpers for the HI/LO execute stage: the op encoding
// and small classifiers used by both the stage and the iterative engine.
package pipeline_mdu_stage_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_t;

    // Ops that occupy the iterative engine for WIDTH cycles
    function automatic logic is_iter(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

    // Ops that use the shift-add multiplier path
    function automatic logic is_mul_op(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_MULTU};
    endfunction

    // Ops that interpret their operands as two's complement
    function automatic logic is_signed_op(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_DIV};
    endfunction

endpackage

// File: rtl/pipeline_mdu_stage_iter_core.sv
// Iterative multiply/divide engine. A shift-add multiplier and a restoring
// divider share one WIDTH+1 bit adder and work on operand magnitudes; the
// sign fix-up is applied to the last iteration's result so the stage can
// commit HI/LO on the same edge that performs the final iteration.
module pipeline_mdu_stage_iter_core
    import pipeline_mdu_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             step,
    input  logic             is_mul,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   low;
    logic [WIDTH-1:0]   opnd;
    logic               mul_mode;
    logic               neg_main;
    logic               neg_rem;

    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   low_next;
    logic [2*WIDTH-1:0] product;

    // Operand magnitudes taken at start; unsigned ops pass straight through
    always_comb begin
        rs_mag = (is_signed && rs[WIDTH-1]) ? -rs : rs;
        rt_mag = (is_signed && rt[WIDTH-1]) ? -rt : rt;
    end

    // Adder operand select: accumulate for multiply, trial subtract for divide
    always_comb begin
        shifted = {acc, low[WIDTH-1]};
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (mul_mode) begin
            add_a = {1'b0, acc};
            add_b = low[0] ? {1'b0, opnd} : '0;
        end else begin
            add_a   = shifted;
            add_b   = ~{1'b0, opnd};
            add_cin = 1'b1;
        end
    end

    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

    // Next iteration state; for divide the carry out means "no borrow"
    always_comb begin
        acc_next = acc;
        low_next = low;
        if (mul_mode) begin
            {acc_next, low_next} = {add_sum[WIDTH:0], low[WIDTH-1:1]};
        end else begin
            acc_next = add_sum[WIDTH+1] ? add_sum[WIDTH-1:0] : shifted[WIDTH-1:0];
            low_next = {low[WIDTH-2:0], add_sum[WIDTH+1]};
        end
    end

    // Signed fix-up of the post-iteration values, valid on the final step
    always_comb begin
        product = {acc_next, low_next};
        if (neg_main) begin
            product = -product;
        end
        if (mul_mode) begin
            res_hi = product[2*WIDTH-1:WIDTH];
            res_lo = product[WIDTH-1:0];
        end else begin
            res_hi = neg_rem  ? -acc_next : acc_next;
            res_lo = neg_main ? -low_next : low_next;
        end
    end

    // Engine registers: load on start, advance one iteration per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            mul_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (abort) begin
            acc      <= '0;
            low      <= '0;
            opnd     <= '0;
            mul_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (start) begin
            acc      <= '0;
            low      <= is_mul ? rt_mag : rs_mag;
            opnd     <= is_mul ? rs_mag : rt_mag;
            mul_mode <= is_mul;
            neg_main <= is_signed & (rs[WIDTH-1] ^ rt[WIDTH-1]);
            neg_rem  <= is_signed & rs[WIDTH-1];
        end else if (step) begin
            acc <= acc_next;
            low <= low_next;
        end
    end

endmodule

// File: rtl/pipeline_mdu_stage.sv
// Execute-side pipeline stage for MIPS HI/LO operations. Holds the stage
// input register, the busy counter for the iterative engine and the
// architectural HI/LO registers, and reports available/output to the CU.
module pipeline_mdu_stage
    import pipeline_mdu_stage_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    input  mdu_op_t          in_op,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    input  logic [4:0]       in_dst,
    output logic             stage_available,
    output logic             stage_output,
    output mdu_op_t          out_op,
    output logic [4:0]       out_dst,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic             valid;
    logic             busy;
    logic [CW-1:0]    cnt;
    logic             take_load;
    logic             do_flush;
    logic             start;
    logic             step;
    logic             finish;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;

    // Edge decisions; a busy engine also holds the slot so a new op can never clobber it
    always_comb begin
        do_flush  = ~stall & bubble;
        take_load = ~stall & ~bubble & ~busy;
        start     = take_load & in_valid & is_iter(in_op);
        step      = busy & ~do_flush;
        finish    = step & (cnt == '0);
    end

    assign stage_available = ~busy;
    assign stage_output    = valid & ~busy;

    pipeline_mdu_stage_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (do_flush & busy),
        .step      (step),
        .is_mul    (is_mul_op(in_op)),
        .is_signed (is_signed_op(in_op)),
        .rs        (in_rs),
        .rt        (in_rt),
        .res_hi    (core_hi),
        .res_lo    (core_lo)
    );

    // Stage slot: hold on stall, empty on bubble, otherwise capture upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            out_op     <= MDU_NOP;
            out_dst    <= '0;
            out_result <= '0;
        end else if (do_flush) begin
            valid      <= 1'b0;
            out_op     <= MDU_NOP;
            out_dst    <= '0;
            out_result <= '0;
        end else if (take_load) begin
            valid   <= in_valid;
            out_op  <= in_op;
            out_dst <= in_dst;
            if (in_valid && in_op == MDU_MFHI) begin
                out_result <= hi;
            end else if (in_valid && in_op == MDU_MFLO) begin
                out_result <= lo;
            end else begin
                out_result <= '0;
            end
        end
    end

    // Busy counter: WIDTH iterations from the load edge, cancelled by a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (do_flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(WIDTH - 1);
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // HI/LO: engine commit on its final step, MTHI/MTLO write at their load edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= HILO_RST;
            lo <= HILO_RST;
        end else if (finish) begin
            hi <= core_hi;
            lo <= core_lo;
        end else if (take_load && in_valid) begin
            if (in_op == MDU_MTHI) begin
                hi <= in_rs;
            end
            if (in_op == MDU_MTLO) begin
                lo <= in_rs;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mdu_stage.sv
// Self-checking bench for pipeline_mdu_stage: directed vector table for the
// iterative ops, hand sequences for flush/stall/reset corners, and random
// ops checked against an arithmetic model of HI/LO.
module tb_pipeline_mdu_stage;
    import pipeline_mdu_stage_pkg::*;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        bubble;
    logic        in_valid;
    mdu_op_t     in_op;
    logic [31:0] in_rs;
    logic [31:0] in_rt;
    logic [4:0]  in_dst;
    logic        stage_available;
    logic        stage_output;
    mdu_op_t     out_op;
    logic [4:0]  out_dst;
    logic [31:0] out_result;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mhi;
    logic [31:0] mlo;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    pipeline_mdu_stage #(
        .WIDTH    (WIDTH),
        .HILO_RST ('0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .bubble          (bubble),
        .in_valid        (in_valid),
        .in_op           (in_op),
        .in_rs           (in_rs),
        .in_rt           (in_rt),
        .in_dst          (in_dst),
        .stage_available (stage_available),
        .stage_output    (stage_output),
        .out_op          (out_op),
        .out_dst         (out_dst),
        .out_result      (out_result),
        .hi              (hi),
        .lo              (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic s, input logic b, input logic v, input mdu_op_t op,
                                 input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] dst);
        stall    = s;
        bubble   = b;
        in_valid = v;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_dst   = dst;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference HI/LO for an iterative op, from plain 64-bit arithmetic
    task automatic modelIter(input mdu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                             output logic [31:0] eh, output logic [31:0] el);
        longint      a;
        longint      b;
        longint      q;
        longint      r;
        logic [63:0] u;
        a  = longint'($signed(rs));
        b  = longint'($signed(rt));
        eh = '0;
        el = '0;
        case (op)
            MDU_MULT: begin
                u = 64'(a * b);
                {eh, el} = u;
            end
            MDU_MULTU: begin
                u = {32'd0, rs} * {32'd0, rt};
                {eh, el} = u;
            end
            MDU_DIVU: begin
                if (rt == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = rs;
                end else begin
                    el = rs / rt;
                    eh = rs % rt;
                end
            end
            MDU_DIV: begin
                if (rt == 32'd0) begin
                    el = (a < 0) ? 32'd1 : 32'hFFFF_FFFF;
                    eh = rs;
                end else begin
                    q  = a / b;
                    r  = a % b;
                    u  = 64'(q);
                    el = u[31:0];
                    u  = 64'(r);
                    eh = u[31:0];
                end
            end
            default: ;
        endcase
    endtask

    task automatic runIter(input mdu_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] eh, input logic [31:0] el, input string tag);
        int busyCycles;
        applyStimulus(1'b0, 1'b0, 1'b1, op, rs, rt, 5'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, MDU_NOP, '0, '0, '0);
        busyCycles = 0;
        while (stage_available == 1'b0 && busyCycles < 100) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput({tag, " busy_cycles"}, 64'(busyCycles), 64'(WIDTH));
        checkOutput({tag, " output"}, 64'(stage_output), 64'd1);
        checkOutput({tag, " hi"}, 64'(hi), 64'(eh));
        checkOutput({tag, " lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        checkOutput({tag, " held_output"}, 64'(stage_output), 64'd1);
        checkOutput({tag, " held_op"}, 64'(out_op), 64'(op));
        applyStimulus(1'b0, 1'b1, 1'b0, MDU_NOP, '0, '0, '0);
        @(negedge clk);
        checkOutput({tag, " flushed_output"}, 64'(stage_output), 64'd0);
        mhi = eh;
        mlo = el;
    endtask

    task automatic runMove(input mdu_op_t op, input logic [31:0] val);
        applyStimulus(1'b0, 1'b0, 1'b1, op, val, '0, 5'd0);
        @(negedge clk);
        if (op == MDU_MTHI) mhi = val;
        else                mlo = val;
        checkOutput("mt output", 64'(stage_output), 64'd1);
        checkOutput("mt available", 64'(stage_available), 64'd1);
        checkOutput("mt hi", 64'(hi), 64'(mhi));
        checkOutput("mt lo", 64'(lo), 64'(mlo));
    endtask

    task automatic runFrom(input mdu_op_t op, input logic [4:0] dst);
        applyStimulus(1'b0, 1'b0, 1'b1, op, $urandom, $urandom, dst);
        @(negedge clk);
        checkOutput("mf result", 64'(out_result), 64'((op == MDU_MFHI) ? mhi : mlo));
        checkOutput("mf dst", 64'(out_dst), 64'(dst));
        checkOutput("mf output", 64'(stage_output), 64'd1);
        checkOutput("mf available", 64'(stage_available), 64'd1);
    endtask

    initial begin
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] eh;
        logic [31:0] el;
        mdu_op_t     op;
        int          sel;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};
        vecs[3] = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[4] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[6] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        vecs[7] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd1};

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, MDU_NOP, '0, '0, '0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset available", 64'(stage_available), 64'd1);
        checkOutput("reset output", 64'(stage_output), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset out_op", 64'(out_op), 64'd0);
        checkOutput("reset out_dst", 64'(out_dst), 64'd0);
        checkOutput("reset out_result", 64'(out_result), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            runIter(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp_hi, vecs[i].exp_lo,
                    $sformatf("vec%0d", i));
        end

        $display("[TB] MTLO then MFLO back to back");
        runMove(MDU_MTLO, 32'h0000_1234);
        runFrom(MDU_MFLO, 5'd9);
        checkOutput("mflo op", 64'(out_op), 64'(MDU_MFLO));

        $display("[TB] flush during MULT");
        applyStimulus(1'b0, 1'b0, 1'b1, MDU_MULT, 32'd1234, 32'd5678, 5'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, MDU_NOP, '0, '0, '0);
        repeat (9) @(negedge clk);
        checkOutput("flush busy before", 64'(stage_available), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, MDU_NOP, '0, '0, '0);
        @(negedge clk);
        checkOutput("flush available", 64'(stage_available), 64'd1);
        checkOutput("flush output", 64'(stage_output), 64'd0);
        checkOutput("flush hi", 64'(hi), 64'(mhi));
        checkOutput("flush lo", 64'(lo), 64'(mlo));
        repeat (40) @(negedge clk);
        checkOutput("flush hi later", 64'(hi), 64'(mhi));
        checkOutput("flush lo later", 64'(lo), 64'(mlo));

        $display("[TB] stall and bubble on loaded MFHI");
        runMove(MDU_MTHI, 32'h0000_ABCD);
        runFrom(MDU_MFHI, 5'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, MDU_MFLO, '0, '0, 5'd7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("stallbub output", 64'(stage_output), 64'd1);
        checkOutput("stallbub op", 64'(out_op), 64'(MDU_MFHI));
        checkOutput("stallbub dst", 64'(out_dst), 64'd3);
        checkOutput("stallbub result", 64'(out_result), 64'h0000_ABCD);

        $display("[TB] unknown op behaves as NOP with output");
        applyStimulus(1'b0, 1'b0, 1'b1, mdu_op_t'(4'hC), 32'h5555_5555, 32'h1, 5'd4);
        @(negedge clk);
        checkOutput("badop output", 64'(stage_output), 64'd1);
        checkOutput("badop available", 64'(stage_available), 64'd1);
        checkOutput("badop hi", 64'(hi), 64'(mhi));
        checkOutput("badop lo", 64'(lo), 64'(mlo));
        checkOutput("badop result", 64'(out_result), 64'd0);

        $display("[TB] random ops against model");
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 5);
            rs  = $urandom;
            rt  = $urandom;
            if ($urandom_range(0, 7) == 0)      rt = '0;
            else if ($urandom_range(0, 3) == 0) rt = rt & 32'h0000_00FF;
            if (sel < 4) begin
                case (sel)
                    0:       op = MDU_MULT;
                    1:       op = MDU_MULTU;
                    2:       op = MDU_DIV;
                    default: op = MDU_DIVU;
                endcase
                modelIter(op, rs, rt, eh, el);
                runIter(op, rs, rt, eh, el, $sformatf("rand%0d", i));
            end else if (sel == 4) begin
                runMove(($urandom_range(0, 1) == 1) ? MDU_MTHI : MDU_MTLO, rs);
            end else begin
                runFrom(($urandom_range(0, 1) == 1) ? MDU_MFHI : MDU_MFLO, 5'($urandom_range(0, 31)));
            end
        end

        $display("[TB] reset during DIVU");
        applyStimulus(1'b0, 1'b0, 1'b1, MDU_DIVU, 32'd5, 32'd0, 5'd0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, MDU_NOP, '0, '0, '0);
        repeat (5) @(negedge clk);
        checkOutput("midreset busy before", 64'(stage_available), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset available", 64'(stage_available), 64'd1);
        checkOutput("midreset output", 64'(stage_output), 64'd0);
        checkOutput("midreset hi", 64'(hi), 64'd0);
        checkOutput("midreset lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
